// File: rtl/dcfifo_reg_pkg.sv
// Shared constants for the dc_fifo_wrapper register-port sequencer:
// FSM encodings, error codes, read-pipe tags and register addresses.
package dcfifo_reg_pkg;

  localparam int unsigned ST_W = 4;

  localparam logic [ST_W-1:0] S_IDLE     = 4'd0;
  localparam logic [ST_W-1:0] S_RST_WR   = 4'd1;
  localparam logic [ST_W-1:0] S_RST_WAIT = 4'd2;
  localparam logic [ST_W-1:0] S_CFG_WR   = 4'd3;
  localparam logic [ST_W-1:0] S_CFG_RD   = 4'd4;
  localparam logic [ST_W-1:0] S_CFG_CHK  = 4'd5;
  localparam logic [ST_W-1:0] S_ST_RD    = 4'd6;
  localparam logic [ST_W-1:0] S_ST_CHK   = 4'd7;
  localparam logic [ST_W-1:0] S_FIN      = 4'd8;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_CFG = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  // Owner of an outstanding read, carried through the read pipe
  localparam logic TAG_FSM  = 1'b0;
  localparam logic TAG_HOST = 1'b1;

  // Wrapper register map
  localparam int unsigned DCFIFO_REG_ADDR_RESET  = 32'h00;
  localparam int unsigned DCFIFO_REG_ADDR_CFG    = 32'h01;
  localparam int unsigned DCFIFO_REG_ADDR_STATUS = 32'h02;

endpackage

// File: rtl/dcfifo_reg_rdpipe.sv
// Valid/tag delay line: marks the cycle reg_rdata becomes valid for an
// issued read and tells whether the host or the sequencer owns it.
module dcfifo_reg_rdpipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_tag,
  output logic out_vld,
  output logic out_tag
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] tag_q, tag_d;

  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = in_vld;
    tag_d[0] = in_tag;
    for (int i = 1; i < int'(DEPTH); i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/dcfifo_cfg_seq.sv
// Register-port master for dc_fifo_wrapper: runs the reset/CFG/STATUS init
// sequence on start and forwards host accesses to the same bus when idle.
module dcfifo_cfg_seq
  import dcfifo_reg_pkg::*;
#(
  parameter int unsigned REG_DW   = 8,
  parameter int unsigned REG_AW   = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned POLL_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REG_DW-1:0] cfg_val,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [REG_DW-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [REG_DW-1:0] host_rdata,
  output logic              reg_req,
  output logic              reg_wr,
  output logic [REG_AW-1:0] reg_addr,
  output logic [REG_DW-1:0] reg_wdata,
  input  logic [REG_DW-1:0] reg_rdata
);

  localparam int unsigned CNT_W  = $clog2(SETTLE + 1);
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic [REG_DW-1:0] cfg_q, cfg_d;
  logic [REG_DW-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              rd_wait_q, rd_wait_d;
  logic [1:0]        err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              host_pending_q, host_pending_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [REG_DW-1:0] host_rdata_q, host_rdata_d;
  logic              reg_req_q, reg_req_d;
  logic              reg_wr_q, reg_wr_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [REG_DW-1:0] reg_wdata_q, reg_wdata_d;
  logic              rd_tag_q, rd_tag_d;

  logic pipe_vld, pipe_tag;
  logic fsm_ret, host_ret, can_issue;

  dcfifo_reg_rdpipe #(.DEPTH(RD_LAT)) u_rdpipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (reg_req_q & ~reg_wr_q),
    .in_tag  (rd_tag_q),
    .out_vld (pipe_vld),
    .out_tag (pipe_tag)
  );

  assign host_ready = (state_q == S_IDLE) & ~start & ~host_pending_q;
  assign fsm_ret    = pipe_vld & (pipe_tag == TAG_FSM);
  assign host_ret   = pipe_vld & (pipe_tag == TAG_HOST);
  // No issue while the previous access is still on the bus (keeps a gap cycle)
  assign can_issue  = ~reg_req_q & ~rd_wait_q;

  always_comb begin
    state_d        = state_q;
    cfg_d          = cfg_q;
    rdata_d        = rdata_q;
    cnt_d          = cnt_q;
    poll_d         = poll_q;
    rd_wait_d      = rd_wait_q;
    err_d          = err_q;
    host_pending_d = host_pending_q;
    host_rvalid_d  = 1'b0;
    host_rdata_d   = host_rdata_q;
    reg_req_d      = 1'b0;
    reg_wr_d       = 1'b0;
    reg_addr_d     = '0;
    reg_wdata_d    = '0;
    rd_tag_d       = rd_tag_q;

    if (host_ret) begin
      host_rvalid_d  = 1'b1;
      host_rdata_d   = reg_rdata;
      host_pending_d = 1'b0;
    end
    // A host write holds off the next accept only for its issue cycle
    if (host_pending_q && reg_req_q && reg_wr_q) begin
      host_pending_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !host_pending_q) begin
          state_d = S_RST_WR;
          cfg_d   = cfg_val;
          err_d   = ERR_OK;
        end else if (host_req && host_ready) begin
          reg_req_d      = 1'b1;
          reg_wr_d       = host_wr;
          reg_addr_d     = host_addr;
          reg_wdata_d    = host_wr ? host_wdata : '0;
          rd_tag_d       = TAG_HOST;
          host_pending_d = 1'b1;
        end
      end
      S_RST_WR: begin
        if (!reg_req_q) begin
          reg_req_d   = 1'b1;
          reg_wr_d    = 1'b1;
          reg_addr_d  = REG_AW'(DCFIFO_REG_ADDR_RESET);
          reg_wdata_d = REG_DW'(1);
          cnt_d       = '0;
          state_d     = S_RST_WAIT;
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = S_CFG_WR;
        end
        cnt_d = (cnt_q == CNT_W'(SETTLE)) ? cnt_q : cnt_q + CNT_W'(1);
      end
      S_CFG_WR: begin
        if (!reg_req_q) begin
          reg_req_d   = 1'b1;
          reg_wr_d    = 1'b1;
          reg_addr_d  = REG_AW'(DCFIFO_REG_ADDR_CFG);
          reg_wdata_d = cfg_q;
          state_d     = S_CFG_RD;
        end
      end
      S_CFG_RD: begin
        if (fsm_ret) begin
          rdata_d   = reg_rdata;
          rd_wait_d = 1'b0;
          state_d   = S_CFG_CHK;
        end else if (can_issue) begin
          reg_req_d  = 1'b1;
          reg_addr_d = REG_AW'(DCFIFO_REG_ADDR_CFG);
          rd_tag_d   = TAG_FSM;
          rd_wait_d  = 1'b1;
        end
      end
      S_CFG_CHK: begin
        if (rdata_q != cfg_q) begin
          err_d   = ERR_CFG;
          state_d = S_FIN;
        end else begin
          poll_d  = '0;
          state_d = S_ST_RD;
        end
      end
      S_ST_RD: begin
        if (fsm_ret) begin
          rdata_d   = reg_rdata;
          rd_wait_d = 1'b0;
          state_d   = S_ST_CHK;
        end else if (can_issue) begin
          reg_req_d  = 1'b1;
          reg_addr_d = REG_AW'(DCFIFO_REG_ADDR_STATUS);
          rd_tag_d   = TAG_FSM;
          rd_wait_d  = 1'b1;
          poll_d     = (poll_q == POLL_W'(POLL_MAX)) ? poll_q : poll_q + POLL_W'(1);
        end
      end
      S_ST_CHK: begin
        // Done once the FIFO reports empty and not full
        if (rdata_q[1] && !rdata_q[0]) begin
          err_d   = ERR_OK;
          state_d = S_FIN;
        end else if (poll_q == POLL_W'(POLL_MAX)) begin
          err_d   = ERR_TMO;
          state_d = S_FIN;
        end else begin
          state_d = S_ST_RD;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cfg_q          <= '0;
      rdata_q        <= '0;
      cnt_q          <= '0;
      poll_q         <= '0;
      rd_wait_q      <= 1'b0;
      err_q          <= ERR_OK;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      host_pending_q <= 1'b0;
      host_rvalid_q  <= 1'b0;
      host_rdata_q   <= '0;
      reg_req_q      <= 1'b0;
      reg_wr_q       <= 1'b0;
      reg_addr_q     <= '0;
      reg_wdata_q    <= '0;
      rd_tag_q       <= TAG_FSM;
    end else begin
      state_q        <= state_d;
      cfg_q          <= cfg_d;
      rdata_q        <= rdata_d;
      cnt_q          <= cnt_d;
      poll_q         <= poll_d;
      rd_wait_q      <= rd_wait_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      host_pending_q <= host_pending_d;
      host_rvalid_q  <= host_rvalid_d;
      host_rdata_q   <= host_rdata_d;
      reg_req_q      <= reg_req_d;
      reg_wr_q       <= reg_wr_d;
      reg_addr_q     <= reg_addr_d;
      reg_wdata_q    <= reg_wdata_d;
      rd_tag_q       <= rd_tag_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign reg_req     = reg_req_q;
  assign reg_wr      = reg_wr_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;

endmodule

// File: tb/tb_dcfifo_cfg_seq.sv
// Directed bench for dcfifo_cfg_seq against a small behavioural model of the
// wrapper register port (RESET clears CFG, CFG read-back, stubbed STATUS).
module tb_dcfifo_cfg_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_val = '0;
  logic       busy, done;
  logic [1:0] err;
  logic       host_req = 1'b0;
  logic       host_wr = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_ready, host_rvalid;
  logic [7:0] host_rdata;
  logic       reg_req, reg_wr;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcfifo_cfg_seq dut (
    .clk(clk), .rst(rst), .start(start), .cfg_val(cfg_val),
    .busy(busy), .done(done), .err(err),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  // Wrapper model: one-cycle read latency, RESET clears CFG
  logic [7:0] m_cfg = 8'h00;
  logic [1:0] m_status = 2'b10;
  logic       m_cfg_zero = 1'b0;
  logic       m_prev_req = 1'b0;
  int         m_b2b = 0;
  logic [7:0] q_addr[$];
  logic       q_wr[$];
  logic [7:0] q_wd[$];

  always @(posedge clk) begin
    m_prev_req <= reg_req;
    if (reg_req && m_prev_req) m_b2b <= m_b2b + 1;
    if (reg_req) begin
      q_addr.push_back(reg_addr);
      q_wr.push_back(reg_wr);
      q_wd.push_back(reg_wdata);
      if (reg_wr) begin
        if (reg_addr == 8'h00) m_cfg <= 8'h00;
        else if (reg_addr == 8'h01) m_cfg <= reg_wdata;
      end else begin
        if (reg_addr == 8'h01) reg_rdata <= m_cfg_zero ? 8'h00 : m_cfg;
        else if (reg_addr == 8'h02) reg_rdata <= {6'b0, m_status};
        else reg_rdata <= 8'h00;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start and wait (bounded) for done; optionally retry start mid-run
  task automatic run_seq(input logic [7:0] cv, input int bound, input bit inject,
                         output bit saw_done, output logic [1:0] e);
    saw_done = 0;
    e = 2'b11;
    @(negedge clk); start = 1'b1; cfg_val = cv;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < bound && !saw_done; i++) begin
      @(negedge clk);
      if (inject && i == 5) begin start = 1'b1; cfg_val = 8'hFF; end
      if (inject && i == 6) start = 1'b0;
      if (done) begin saw_done = 1; e = err; end
    end
  endtask

  function automatic int count_addr(input int from, input logic [7:0] a);
    int n = 0;
    for (int i = from; i < q_addr.size(); i++) if (q_addr[i] == a && !q_wr[i]) n++;
    return n;
  endfunction

  initial begin
    bit         sd;
    logic [1:0] e;
    int         mark;
    bit         found;
    bit         dn;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_reg_req", reg_req, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_host_ready", host_ready, 1);

    // Normal init sequence, with a second start while busy
    m_status = 2'b10;
    mark = q_addr.size();
    run_seq(8'h01, 200, 1, sd, e);
    check("seq_done", sd, 1);
    check("seq_err", e, 0);
    check("seq_nacc", q_addr.size() - mark, 4);
    if (q_addr.size() - mark == 4) begin
      check("seq_a0", {q_wr[mark], q_addr[mark], q_wd[mark]}, {1'b1, 8'h00, 8'h01});
      check("seq_a1", {q_wr[mark+1], q_addr[mark+1], q_wd[mark+1]}, {1'b1, 8'h01, 8'h01});
      check("seq_a2", {q_wr[mark+2], q_addr[mark+2]}, {1'b0, 8'h01});
      check("seq_a3", {q_wr[mark+3], q_addr[mark+3]}, {1'b0, 8'h02});
    end
    check("seq_fwft", m_cfg, 8'h01);
    @(negedge clk);
    check("done_pulse_1cyc", done, 0);
    check("err_held", err, 0);

    // CFG read-back mismatch
    m_cfg_zero = 1'b1;
    mark = q_addr.size();
    run_seq(8'h01, 200, 0, sd, e);
    m_cfg_zero = 1'b0;
    check("mis_done", sd, 1);
    check("mis_err", e, 1);
    check("mis_nacc", q_addr.size() - mark, 3);
    check("mis_nstatus", count_addr(mark, 8'h02), 0);

    // STATUS stuck full: timeout after POLL_MAX reads
    m_status = 2'b01;
    mark = q_addr.size();
    run_seq(8'h01, 2000, 0, sd, e);
    check("tmo_done", sd, 1);
    check("tmo_err", e, 2);
    check("tmo_nstatus", count_addr(mark, 8'h02), 64);
    m_status = 2'b10;

    // Host read of CFG while idle: rvalid two edges after acceptance
    @(negedge clk);
    host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h01;
    #1 check("hrd_ready", host_ready, 1);
    @(negedge clk);
    host_req = 1'b0;
    #1 check("hrd_issue", {reg_req, reg_wr, reg_addr}, {1'b1, 1'b0, 8'h01});
    check("hrd_rvalid_e1", host_rvalid, 0);
    @(negedge clk); #1 check("hrd_rvalid_e2", host_rvalid, 0);
    @(negedge clk); #1 check("hrd_rvalid", host_rvalid, 1);
    check("hrd_rdata", host_rdata, 8'h01);
    @(negedge clk); #1 check("hrd_rvalid_pulse", host_rvalid, 0);

    // Host write of CFG
    host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h01; host_wdata = 8'h03;
    @(negedge clk);
    host_req = 1'b0;
    #1 check("hwr_no_ready_next", host_ready, 0);
    @(negedge clk);
    check("hwr_cfg", m_cfg, 8'h03);

    // start and host_req together: start wins, host goes after done
    @(negedge clk);
    start = 1'b1; cfg_val = 8'h01;
    host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h05; host_wdata = 8'hA5;
    #1 check("arb_ready_start", host_ready, 0);
    found = 0; dn = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) dn = 1;
      if (host_ready) found = 1;
    end
    check("arb_ready_seen", found, 1);
    check("arb_after_done", dn, 1);
    @(negedge clk);
    host_req = 1'b0; host_wr = 1'b0;
    #1 check("arb_host_issue", {reg_req, reg_wr, reg_addr, reg_wdata}, {1'b1, 1'b1, 8'h05, 8'hA5});
    check("arb_err", err, 0);

    // Reset while polling STATUS, then a clean rerun
    repeat (2) @(negedge clk);
    m_status = 2'b01;
    @(negedge clk); start = 1'b1; cfg_val = 8'h01;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (reg_req && !reg_wr && reg_addr == 8'h02) found = 1;
    end
    check("rst_mid_reached_st", found, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_reg_req", reg_req, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_done", done, 0);
    rst = 1'b0;
    m_status = 2'b10;
    repeat (3) @(negedge clk);
    check("rst_mid_idle_done", done, 0);
    mark = q_addr.size();
    run_seq(8'h01, 200, 0, sd, e);
    check("rerun_done", sd, 1);
    check("rerun_err", e, 0);
    check("rerun_nacc", q_addr.size() - mark, 4);
    check("no_back_to_back", m_b2b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
